beacon_keyer: RTL and testbench
===============================

# beacon_keyer

Byte-to-OOK keying stage between the 1200-baud UART receiver and the RF transmitter of the phase_dsp beacon. It accepts received bytes on a strobe, buffers them in a small FIFO, and plays them out as a framed on/off-keyed symbol stream on `tx_en`. `tx_en` gates the carrier in the tx block and forces the hex_dump sample input high while keyed. Symbol timing is derived from the 48 MHz crystal clock.

## Interface
- SYM_CNT, 40000, clock cycles per symbol (48 MHz / 1200 baud)
- PRE_LEN, 8, preamble symbols per frame, even, ≥2
- GAP_LEN, 4, trailing carrier-off guard symbols per frame, ≥1
- DEPTH, 8, FIFO depth in bytes, power of two, ≥2

- clk  in  1  xtal clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_dat  in  8  received byte, valid when rx_stb=1
- rx_stb  in  1  one-cycle strobe, byte available
- tx_en  out  1  carrier keying, 1 = carrier on; registered
- busy  out  1  1 from frame start through last gap symbol
- frame_done  out  1  one-cycle pulse after last gap symbol
- overflow  out  1  sticky; set when a byte is dropped, cleared only by rst

## Operation
- Reset (async): tx_en=0, busy=0, frame_done=0, overflow=0, FIFO empty, FSM=IDLE, symbol counter=0.
- FIFO: push on rx_stb when not full. A push while full is dropped and sets overflow. The exception is a same-cycle pop: push and pop in the same cycle on a full FIFO both succeed, with no overflow.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. full/empty come from MSB compare.
- Symbol counter: counts 0..SYM_CNT-1, width $clog2(SYM_CNT). Symbol boundary (tick) when count = SYM_CNT-1. Counter is held at 0 in IDLE.
- FSM states and transitions:
  - IDLE: tx_en=0. If FIFO non-empty, go to PRE, busy=1.
  - PRE: tx_en alternates 1,0,1,0… starting with 1, for PRE_LEN symbols. After the last symbol, go to LOAD.
  - LOAD: single cycle. Pop FIFO head into 8-bit shift register, then go to START. No symbol time elapses.
  - START: tx_en=1 for 1 symbol, then DATA.
  - DATA: 8 symbols, tx_en = shift[0], LSB first. Shift right on each tick. Then STOP.
  - STOP: tx_en=0 for 1 symbol. Then go to LOAD if FIFO non-empty, else GAP. There is no preamble between bytes of one frame.
  - GAP: tx_en=0 for GAP_LEN symbols. On the last tick, go to IDLE, drop busy, and pulse frame_done for 1 cycle.
- tx_en is a registered output of the FSM and shift register; it has no glitches.
- Bytes arriving during a frame are appended to the same frame while they arrive before STOP ends.

## Timing
- rx_stb in IDLE at cycle t: byte stored at t+1, FSM in PRE at t+2, tx_en=1 and busy=1 visible at t+2.
- Each symbol lasts exactly SYM_CNT cycles. Each LOAD adds 1 cycle before START.
- Frame of N bytes spans PRE_LEN·SYM_CNT + N·(10·SYM_CNT+1) + GAP_LEN·SYM_CNT cycles of busy=1.
- frame_done is asserted in the cycle busy falls. The next frame can begin (PRE) on the following cycle if the FIFO is non-empty.
- The POP in LOAD and a push in the same cycle both take effect.
- Reset mid-frame: tx_en drops asynchronously. Contents in progress are discarded, with no frame_done.

## Test plan
Use SYM_CNT=4, PRE_LEN=4, GAP_LEN=2, DEPTH=4 throughout.
- Single byte 0xA5 in IDLE:
  - Per-symbol tx_en is 1,0,1,0 | 1 | 1,0,1,0,0,1,0,1 | 0 | 0,0.
  - busy high for 65 cycles, then one frame_done pulse.
- Bytes 0x00 and 0xFF, 10 cycles apart:
  - One frame: preamble once, then 1,00000000,0 and 1,11111111,0, then gap.
  - busy high for 4·4+2·41+2·4 = 106 cycles.
- Six rx_stb on consecutive cycles with bytes 0x01..0x06:
  - 0x01 is popped at LOAD after the preamble, so 0x05 is dropped as well as 0x06; overflow=1.
  - Exactly 4 bytes (0x01..0x04) are transmitted, and overflow stays 1 after frame_done.
- Full FIFO with push on the LOAD cycle: the byte is accepted, overflow stays 0, and all bytes appear in order.
- rst asserted mid-DATA:
  - tx_en=0 and busy=0 immediately, FIFO empty.
  - After release, a new byte 0x3C produces a full correct frame.
- rx_stb during GAP: the current frame ends with frame_done, then a new preamble starts on the next cycle.

Source files
------------

// File: rtl/beacon_keyer_if.sv
// rtl/beacon_keyer_if.sv - byte strobe in, OOK keying and frame status out
interface beacon_keyer_if;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       tx_en;
  logic       busy;
  logic       frame_done;
  logic       overflow;

  modport master (
    output rx_dat, rx_stb,
    input  tx_en, busy, frame_done, overflow
  );

  modport slave (
    input  rx_dat, rx_stb,
    output tx_en, busy, frame_done, overflow
  );
endinterface

// File: rtl/beacon_keyer.sv
// rtl/beacon_keyer.sv - buffers received bytes and keys them out as framed OOK symbols
module beacon_keyer #(
  parameter int SYM_CNT = 40000,
  parameter int PRE_LEN = 8,
  parameter int GAP_LEN = 4,
  parameter int DEPTH   = 8
) (
  input logic           clk,
  input logic           rst,
  beacon_keyer_if.slave bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = (SYM_CNT > 1) ? $clog2(SYM_CNT) : 1;
  localparam int MAXS_A = (PRE_LEN > GAP_LEN) ? PRE_LEN : GAP_LEN;
  localparam int MAXS   = (MAXS_A > 8) ? MAXS_A : 8;
  localparam int IW     = $clog2(MAXS);

  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_CNT - 1);
  localparam logic [IW-1:0] PRE_LAST = IW'(PRE_LEN - 1);
  localparam logic [IW-1:0] GAP_LAST = IW'(GAP_LEN - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(7);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    LOAD,
    START,
    DATA,
    STOP,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] sym_idx;
  logic [7:0]    shift;
  logic          tx_en_q;
  logic          busy_q;
  logic          frame_done_q;
  logic          overflow_q;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          tick;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = (state == LOAD);
  assign push  = bus.rx_stb && (!full || pop);
  assign tick  = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.rx_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.rx_stb && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sym_idx      <= '0;
      shift        <= '0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // LOAD is a bare cycle between symbols, so the counter rests there too.
      if (state == IDLE || state == LOAD || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          tx_en_q <= 1'b0;
          sym_idx <= '0;
          if (!empty) begin
            state   <= PRE;
            busy_q  <= 1'b1;
            tx_en_q <= 1'b1;
          end
        end

        PRE: begin
          if (tick) begin
            if (sym_idx == PRE_LAST) begin
              state   <= LOAD;
              tx_en_q <= 1'b0;
            end else begin
              sym_idx <= sym_idx + 1'b1;
              tx_en_q <= ~tx_en_q;
            end
          end
        end

        LOAD: begin
          shift   <= mem[rd_ptr[AW-1:0]];
          state   <= START;
          tx_en_q <= 1'b1;
        end

        START: begin
          if (tick) begin
            state   <= DATA;
            sym_idx <= '0;
            tx_en_q <= shift[0];
          end
        end

        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (sym_idx == BIT_LAST) begin
              state   <= STOP;
              tx_en_q <= 1'b0;
            end else begin
              sym_idx <= sym_idx + 1'b1;
              tx_en_q <= shift[1];
            end
          end
        end

        STOP: begin
          if (tick) begin
            sym_idx <= '0;
            state   <= empty ? GAP : LOAD;
          end
        end

        GAP: begin
          if (tick) begin
            if (sym_idx == GAP_LAST) begin
              state        <= IDLE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              sym_idx <= sym_idx + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_en      = tx_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_beacon_keyer.sv
// tb/tb_beacon_keyer.sv - scoreboard bench: frames queued at stimulus, keyed waveform rebuilt and compared
module tb_beacon_keyer;

  localparam int SYM = 4;
  localparam int PRE = 4;
  localparam int GAP = 2;
  localparam int DEP = 4;

  logic clk;
  logic rst;

  beacon_keyer_if bus ();

  beacon_keyer #(
    .SYM_CNT(SYM),
    .PRE_LEN(PRE),
    .GAP_LEN(GAP),
    .DEPTH  (DEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected frames: byte count per frame (-1 = frame cut short by reset) plus a flat byte queue.
  int         exp_len_q[$];
  logic [7:0] exp_byte_q[$];

  task automatic check(input string name, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] dats[$]);
    foreach (dats[i]) exp_byte_q.push_back(dats[i]);
    exp_len_q.push_back(dats.size());
  endtask

  task automatic send(input int offs[$], input logic [7:0] dats[$]);
    int k = 0;
    int last = offs[offs.size()-1];
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (k < offs.size() && offs[k] == c) begin
        bus.rx_stb = 1'b1;
        bus.rx_dat = dats[k];
        k++;
      end else begin
        bus.rx_stb = 1'b0;
        bus.rx_dat = 8'h00;
      end
    end
    @(negedge clk);
    bus.rx_stb = 1'b0;
    bus.rx_dat = 8'h00;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_len_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending_frames", exp_len_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: capture tx_en for every busy cycle, then compare with a waveform built from the symbol rules.
  initial begin : monitor
    logic trace[$];
    logic exp_w[$];
    int   n;
    int   bad;
    bit   aborted;
    @(negedge clk);
    forever begin
      if (!(bus.busy && !rst)) begin
        @(negedge clk);
        continue;
      end
      trace.delete();
      aborted = 1'b0;
      while (bus.busy && !aborted) begin
        trace.push_back(bus.tx_en);
        @(negedge clk);
        if (rst) aborted = 1'b1;
        if (trace.size() > 4000) begin
          check("frame_too_long", trace.size(), 4000);
          break;
        end
      end
      check("frame_expected", exp_len_q.size() > 0, 1);
      n = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : 0;
      if (aborted) begin
        check("abort_expected", n, -1);
        for (int i = 0; i < n; i++) void'(exp_byte_q.pop_front());
        continue;
      end
      check("frame_not_aborted", (n >= 0), 1);
      check("frame_done_at_busy_fall", bus.frame_done, 1);
      check("tx_en_off_after_frame", bus.tx_en, 0);
      exp_w.delete();
      for (int p = 0; p < PRE; p++)
        for (int s = 0; s < SYM; s++) exp_w.push_back((p % 2) == 0);
      for (int j = 0; j < n; j++) begin
        logic [7:0] b;
        b = exp_byte_q.pop_front();
        exp_w.push_back(1'b0);
        for (int s = 0; s < SYM; s++) exp_w.push_back(1'b1);
        for (int k = 0; k < 8; k++)
          for (int s = 0; s < SYM; s++) exp_w.push_back(b[k]);
        for (int s = 0; s < SYM; s++) exp_w.push_back(1'b0);
      end
      for (int s = 0; s < GAP * SYM; s++) exp_w.push_back(1'b0);
      check("busy_cycles", trace.size(), exp_w.size());
      bad = -1;
      for (int i = 0; i < trace.size() && i < exp_w.size(); i++) begin
        if (trace[i] !== exp_w[i]) begin
          bad = i;
          break;
        end
      end
      check("tx_en_wave_first_bad_cycle", bad, -1);
      @(negedge clk);
      check("frame_done_single_pulse", bus.frame_done, 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         offs[$];
    logic [7:0] dats[$];
    int         g;
    int         rises;
    int         off;
    int         nb;

    rst        = 1'b1;
    bus.rx_stb = 1'b0;
    bus.rx_dat = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx_en", bus.tx_en, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_frame_done", bus.frame_done, 0);
    check("reset_overflow", bus.overflow, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte.
    expect_frame('{8'hA5});
    send('{0}, '{8'hA5});
    drain();

    // Two bytes ten cycles apart join one frame.
    expect_frame('{8'h00, 8'hFF});
    send('{0, 10}, '{8'h00, 8'hFF});
    drain();
    check("overflow_clear_so_far", bus.overflow, 0);

    // Six back-to-back strobes into a four-deep FIFO.
    expect_frame('{8'h01, 8'h02, 8'h03, 8'h04});
    send('{0, 1, 2, 3, 4, 5}, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    check("overflow_set_on_drop", bus.overflow, 1);
    drain();
    check("overflow_sticky_after_frame", bus.overflow, 1);

    // Reset in the middle of the first data byte, with a second byte still queued.
    exp_len_q.push_back(-1);
    send('{0, 5}, '{8'h77, 8'h88});
    repeat (29) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_data_tx_en", bus.tx_en, 0);
    check("rst_mid_data_busy", bus.busy, 0);
    check("rst_mid_data_frame_done", bus.frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("overflow_cleared_by_rst", bus.overflow, 0);
    rises = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy) rises++;
    end
    check("fifo_empty_after_rst", rises, 0);
    check("abort_consumed", exp_len_q.size(), 0);
    expect_frame('{8'h3C});
    send('{0}, '{8'h3C});
    drain();

    // Full FIFO with a fifth byte arriving on the LOAD cycle (2 + PRE*SYM after the first strobe).
    expect_frame('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    send('{0, 1, 2, 3, 2 + PRE * SYM}, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    drain();
    check("overflow_not_set_on_load_push", bus.overflow, 0);

    // Strobe during the gap: next preamble follows the frame_done cycle directly.
    expect_frame('{8'h5A});
    expect_frame('{8'hC3});
    send('{0, 2 + PRE * SYM + 10 * SYM + 1 + GAP * SYM - 4}, '{8'h5A, 8'hC3});
    g = 0;
    while (!bus.frame_done && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("gap_frame_done_seen", bus.frame_done, 1);
    check("gap_busy_low_on_done", bus.busy, 0);
    @(negedge clk);
    check("gap_next_preamble_busy", bus.busy, 1);
    check("gap_next_preamble_tx_en", bus.tx_en, 1);
    drain();

    // Randomised frames of 1..4 bytes, all queued before the first stop symbol ends.
    for (int it = 0; it < 10; it++) begin
      offs.delete();
      dats.delete();
      nb  = $urandom_range(1, 4);
      off = 0;
      for (int i = 0; i < nb; i++) begin
        offs.push_back(off);
        dats.push_back(8'($urandom));
        off += $urandom_range(1, 6);
      end
      expect_frame(dats);
      send(offs, dats);
      drain();
      check("random_overflow_clear", bus.overflow, 0);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
